// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit common-anode 7-segment scan controller.
package display_pkg;

    typedef enum logic {
        BLANK  = 1'b0,
        ACTIVE = 1'b1
    } scan_state_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    // Active-low {a,b,c,d,e,f,g} patterns for hex digits 0-F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/display_scan_controller_hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    always_comb begin
        segments = HEX_SEG[nibble];
    end

endmodule

// File: rtl/display_scan_controller.sv
// Digit scan sequencer for a 4-digit common-anode display: blanking gap, PWM on-time,
// and a ready/valid value shadow that is committed only at frame boundaries.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned SUB_CYCLES   = 6187
)
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  dp,
    input  logic [3:0]  brightness,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp_n,
    output logic        frame_start
);

    localparam int unsigned CNT_MAX = (BLANK_CYCLES > SUB_CYCLES) ? BLANK_CYCLES : SUB_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SUB_LAST   = CNT_W'(SUB_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       sub, sub_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             boundary;

    logic [15:0]      shadow;
    logic [15:0]      value_act;
    logic [3:0]       en_act;
    logic [3:0]       dp_act;
    logic [3:0]       bright_act;

    logic             lit_nxt;
    logic [3:0]       nibble_nxt;
    logic [6:0]       seg_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        sub_nxt   = sub;
        idx_nxt   = idx;
        boundary  = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = '0;
                    sub_nxt   = '0;
                end
            end
            ACTIVE: begin
                if (cnt == SUB_LAST) begin
                    cnt_nxt = '0;
                    if (sub == 4'hF) begin
                        state_nxt = BLANK;
                        idx_nxt   = idx + 1'b1;
                        boundary  = (idx == IDX_LAST);
                    end else begin
                        sub_nxt = sub + 1'b1;
                    end
                end
            end
            default: state_nxt = BLANK;
        endcase
    end

    // Outputs decode the next-state values so they change on the same edge as the state.
    always_comb begin
        lit_nxt    = (state_nxt == ACTIVE) && (sub_nxt <= bright_act) && en_act[idx_nxt];
        nibble_nxt = value_act[{idx_nxt, 2'b00} +: 4];
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble   (nibble_nxt),
        .segments (seg_nxt)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BLANK;
            cnt         <= '0;
            sub         <= '0;
            idx         <= '0;
            shadow      <= '0;
            value_act   <= '0;
            en_act      <= 4'hF;
            dp_act      <= '0;
            bright_act  <= 4'hF;
            value_ready <= 1'b1;
            anode       <= 4'hF;
            cathode     <= SEG_BLANK;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sub         <= sub_nxt;
            idx         <= idx_nxt;
            frame_start <= boundary;
            anode       <= lit_nxt ? ~(4'b0001 << idx_nxt) : 4'hF;
            cathode     <= lit_nxt ? seg_nxt : SEG_BLANK;
            dp_n        <= lit_nxt ? ~dp_act[idx_nxt] : 1'b1;

            // An accept implies the shadow was empty, so it never collides with a commit.
            if (value_valid && value_ready) begin
                shadow      <= value;
                value_ready <= 1'b0;
            end else if (boundary && !value_ready) begin
                value_act   <= shadow;
                value_ready <= 1'b1;
            end

            if (boundary) begin
                en_act     <= digit_en;
                dp_act     <= dp;
                bright_act <= brightness;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller with an 18-cycle slot / 72-cycle frame.
module tb_display_scan_controller;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value;
    logic        value_valid;
    logic        value_ready;
    logic [3:0]  digit_en;
    logic [3:0]  dp;
    logic [3:0]  brightness;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        dp_n;
    logic        frame_start;

    display_scan_controller #(
        .BLANK_CYCLES (2),
        .SUB_CYCLES   (1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .digit_en    (digit_en),
        .dp          (dp),
        .brightness  (brightness),
        .anode       (anode),
        .cathode     (cathode),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0]     frame;
        logic [3:0][4:0] lit;
        logic [3:0][6:0] seg;
        logic [3:0][4:0] dpc;
    } frame_exp_t;

    typedef struct packed {
        logic [15:0] val;
        logic [15:0] frame;
        logic        at_zero;
    } accept_exp_t;

    frame_exp_t  exp_q[$];
    accept_exp_t acc_q[$];

    int checks = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endfunction

    function automatic void summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endfunction

    // ---------------- monitor: per-frame statistics ----------------
    int         frames_seen = 0;
    bit         in_frame = 0;
    int         ncyc = 0;
    int         lit_cnt[4];
    int         first_off[4];
    int         last_off[4];
    int         dp_cnt[4];
    int         seg_bad[4];
    logic [6:0] seg_seen[4];
    int         bad_anode;
    int         bad_dark;

    function automatic void clear_stats();
        for (int k = 0; k < 4; k++) begin
            lit_cnt[k]   = 0;
            first_off[k] = -1;
            last_off[k]  = -1;
            dp_cnt[k]    = 0;
            seg_bad[k]   = 0;
            seg_seen[k]  = 7'h7F;
        end
        bad_anode = 0;
        bad_dark  = 0;
    endfunction

    function automatic void sample_cycle(int j);
        int s;
        int w;
        logic [3:0] sel;
        s = j / 18;
        w = j % 18;
        if (s > 3) return;
        sel = ~(4'b0001 << s);
        if (anode != 4'hF) begin
            if (anode != sel) begin
                bad_anode++;
            end else begin
                lit_cnt[s]++;
                if (first_off[s] < 0) begin
                    first_off[s] = w;
                    seg_seen[s]  = cathode;
                end else if (cathode != seg_seen[s]) begin
                    seg_bad[s]++;
                end
                last_off[s] = w;
                if (dp_n == 1'b0) dp_cnt[s]++;
            end
        end else if (cathode != 7'h7F || dp_n != 1'b1) begin
            bad_dark++;
        end
    endfunction

    function automatic void finalize_frame(int f);
        frame_exp_t e;
        int n;
        chk($sformatf("frame_len f%0d", f), ncyc, 72);
        while (exp_q.size() > 0 && int'(exp_q[0].frame) < f) begin
            chk("exp_frame_missed", exp_q[0].frame, f);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && int'(exp_q[0].frame) == f) begin
            e = exp_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                n = int'(e.lit[k]);
                chk($sformatf("lit_cycles f%0d d%0d", f, k), lit_cnt[k], n);
                if (n != 0) begin
                    chk($sformatf("first_lit f%0d d%0d", f, k), first_off[k], 2);
                    chk($sformatf("last_lit f%0d d%0d", f, k), last_off[k], 2 + n - 1);
                    chk($sformatf("cathode f%0d d%0d", f, k), seg_seen[k], e.seg[k]);
                    chk($sformatf("cathode_stable f%0d d%0d", f, k), seg_bad[k], 0);
                end
                chk($sformatf("dp_cycles f%0d d%0d", f, k), dp_cnt[k], e.dpc[k]);
            end
            chk($sformatf("bad_anode f%0d", f), bad_anode, 0);
            chk($sformatf("dark_outputs f%0d", f), bad_dark, 0);
        end
    endfunction

    always @(negedge clock) begin
        if (!reset_n) begin
            in_frame = 0;
        end else begin
            if (frame_start) begin
                if (in_frame) finalize_frame(frames_seen);
                frames_seen++;
                in_frame = 1;
                ncyc = 0;
                clear_stats();
            end
            if (in_frame) begin
                sample_cycle(ncyc);
                ncyc++;
            end
        end
    end

    // ---------------- monitor: handshake accepts ----------------
    always @(posedge clock) begin
        accept_exp_t a;
        if (reset_n && value_valid && value_ready) begin
            if (acc_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_accept: got value 0x%0h expected no accept", value);
            end else begin
                a = acc_q.pop_front();
                chk("accept_value", value, a.val);
                chk("accept_frame", frames_seen, a.frame);
                if (a.at_zero) chk("accept_offset", ncyc - 1, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
        end while (!frame_start && n < 300);
        if (!frame_start) begin
            checks++;
            failures++;
            $display("FAIL frame_start_timeout: got no pulse expected one within 300 cycles");
            summary();
            $finish;
        end
    endtask

    task automatic push_frame(int f, logic [27:0] segs, int n, logic [3:0] en, logic [3:0] dpm);
        frame_exp_t e;
        e.frame = f[15:0];
        for (int k = 0; k < 4; k++) begin
            e.seg[k] = segs[7*k +: 7];
            e.lit[k] = en[k] ? n[4:0] : 5'd0;
            e.dpc[k] = (en[k] && dpm[k]) ? n[4:0] : 5'd0;
        end
        exp_q.push_back(e);
    endtask

    task automatic push_accept(logic [15:0] v, int f, logic at_zero);
        accept_exp_t a;
        a.val     = v;
        a.frame   = f[15:0];
        a.at_zero = at_zero;
        acc_q.push_back(a);
    endtask

    localparam logic [27:0] SEG_0000 = {7'h01, 7'h01, 7'h01, 7'h01};
    localparam logic [27:0] SEG_1234 = {7'h4F, 7'h12, 7'h06, 7'h4C};
    localparam logic [27:0] SEG_1111 = {7'h4F, 7'h4F, 7'h4F, 7'h4F};
    localparam logic [27:0] SEG_ABCD = {7'h08, 7'h60, 7'h31, 7'h42};

    initial begin
        int n1;
        int m;
        value       = '0;
        value_valid = 1'b0;
        digit_en    = 4'hF;
        dp          = 4'h0;
        brightness  = 4'hF;
        reset_n     = 1'b0;

        #23;
        chk("reset_anode", anode, 4'hF);
        chk("reset_cathode", cathode, 7'h7F);
        chk("reset_dp_n", dp_n, 1'b1);
        chk("reset_frame_start", frame_start, 1'b0);
        chk("reset_value_ready", value_ready, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;

        wait_frame();
        n1 = frames_seen;
        push_frame(n1, SEG_0000, 16, 4'hF, 4'h0);
        value       = 16'h1234;
        value_valid = 1'b1;
        push_accept(16'h1234, n1, 1'b0);
        @(posedge clock);
        #1;
        value_valid = 1'b0;
        push_frame(n1 + 1, SEG_1234, 16, 4'hF, 4'h0);

        wait_frame();
        brightness = 4'd0;
        push_frame(n1 + 2, SEG_1234, 1, 4'hF, 4'h0);

        wait_frame();
        brightness = 4'd7;
        push_frame(n1 + 3, SEG_1111, 8, 4'hF, 4'h0);
        value       = 16'h1111;
        value_valid = 1'b1;
        push_accept(16'h1111, n1 + 2, 1'b0);
        @(posedge clock);
        #1;
        chk("ready_low_after_accept", value_ready, 1'b0);
        value = 16'hABCD;
        push_accept(16'hABCD, n1 + 3, 1'b1);

        wait_frame();
        digit_en = 4'b0101;
        push_frame(n1 + 4, SEG_ABCD, 8, 4'b0101, 4'h0);
        @(posedge clock);
        #1;
        value_valid = 1'b0;

        wait_frame();
        digit_en = 4'hF;
        dp       = 4'b0010;
        push_frame(n1 + 5, SEG_ABCD, 8, 4'hF, 4'b0010);

        wait_frame();
        dp = 4'h0;

        wait_frame();
        value       = 16'h5678;
        value_valid = 1'b1;
        push_accept(16'h5678, frames_seen, 1'b0);
        @(posedge clock);
        #1;
        value_valid = 1'b0;
        chk("ready_low_pending", value_ready, 1'b0);
        repeat (4) @(negedge clock);
        #1;
        chk("lit_before_reset", anode, 4'b1110);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_anode", anode, 4'hF);
        chk("async_reset_cathode", cathode, 7'h7F);
        chk("async_reset_dp_n", dp_n, 1'b1);
        chk("async_reset_value_ready", value_ready, 1'b1);
        chk("async_reset_frame_start", frame_start, 1'b0);
        brightness = 4'hF;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        wait_frame();
        m = frames_seen;
        push_frame(m, SEG_0000, 16, 4'hF, 4'h0);

        wait_frame();
        chk("frame_queue_drained", exp_q.size(), 0);
        chk("accept_queue_drained", acc_q.size(), 0);
        summary();
        $finish;
    end

    initial begin
        #200000;
        checks++;
        failures++;
        $display("FAIL watchdog: got no completion expected finish before 200us");
        summary();
        $finish;
    end

endmodule
